// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter: FSM state encodings
// and direction constants.
package updown_mod_counter_pkg;

    // RUN counts normally; HALT is the one-shot resting state at terminal count.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // Encoding of the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_mod_counter_step.sv
// Combinational step logic: next count value and terminal-count detect for
// the current direction. Wrapping is done by explicit compares against
// MODULUS-1 so that non-power-of-two moduli never rely on natural rollover.
module mod_counter_step
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] q_step,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_ZERO = '0;

    // Next value in the selected direction, wrapping at either end of the range.
    always_comb begin
        q_step  = q;
        at_term = 1'b0;
        case (up)
            DIR_UP: begin
                at_term = (q == Q_MAX);
                q_step  = at_term ? Q_ZERO : q + WIDTH'(1);
            end
            DIR_DOWN: begin
                at_term = (q == Q_ZERO);
                q_step  = at_term ? Q_MAX : q - WIDTH'(1);
            end
            default: begin
                q_step  = q;
                at_term = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with synchronous load, terminal-count flag, wrap
// pulse and an optional one-shot mode that halts at terminal count.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int ONE_SHOT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             wrap_reg, wrap_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] q_step;
    logic             at_term;

    mod_counter_step #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_step (
        .q      (q_reg),
        .up     (up),
        .q_step (q_step),
        .at_term(at_term)
    );

    // Terminal count is purely combinational on the live inputs and count.
    assign tc   = enable & at_term;
    assign q    = q_reg;
    assign wrap = wrap_reg;
    assign done = done_reg;

    // Next-state logic: load beats counting; HALT ignores enable and direction.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        wrap_next  = 1'b0;
        done_next  = done_reg;
        if (load) begin
            // Out-of-range load values saturate to the top of the range.
            q_next     = (load_value <= Q_MAX) ? load_value : Q_MAX;
            state_next = RUN;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (enable) begin
                        if (at_term && (ONE_SHOT != 0)) begin
                            // One-shot: hold the terminal value and park.
                            state_next = HALT;
                            done_next  = 1'b1;
                            wrap_next  = 1'b1;
                        end else begin
                            q_next    = q_step;
                            wrap_next = at_term;
                        end
                    end
                end
                HALT: begin
                    done_next = 1'b1;
                end
                default: begin
                    state_next = RUN;
                    done_next  = 1'b0;
                end
            endcase
        end
    end

    // All counter state, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            q_reg     <= '0;
            wrap_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            wrap_reg  <= wrap_next;
            done_reg  <= done_next;
        end
    end

endmodule
